// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS-compatible core's multicycle control.
// state_t carries the sequencer state encoding that the datapath and
// monitors rely on; encodings 5-7 are never produced by the sequencer.
package mips_cpu_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/mips_cpu_control_fsm.sv
// Multicycle sequencer: steps each instruction through FETCH, EXEC, MEM and
// WB, drives the Avalon read/write strobes and the IR / PC / register-file
// write enables, stalls on waitrequest and halts once the core jumps to 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   waitrequest         Avalon stall, 1 = current access not complete
//   instr_is_load/store decoded IR memory class (load wins if both set)
//   instr_writes_reg    decoded IR: non-memory instruction writes a register
//   pc_next_is_zero     datapath next PC equals 0 (halt on retire)
//   active              1 while executing, 0 once halted
//   mem_read/mem_write  Avalon strobes
//   ir_write, pc_write, rf_write_enable  datapath write enables
//   state               current state (debug)
//   retired_count       instructions completed since reset, wraps
module mips_cpu_control_fsm
    import mips_cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waitrequest,
    input  logic               instr_is_load,
    input  logic               instr_is_store,
    input  logic               instr_writes_reg,
    input  logic               pc_next_is_zero,
    output logic               active,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               rf_write_enable,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   retired_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        active          = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        rf_write_enable = 1'b0;
        retire          = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                if (!waitrequest) begin
                    ir_write = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (instr_is_load || instr_is_store) begin
                    state_d = MEM;
                end else begin
                    rf_write_enable = instr_writes_reg;
                    pc_write        = 1'b1;
                    retire          = 1'b1;
                    state_d         = pc_next_is_zero ? HALT : FETCH;
                end
            end
            MEM: begin
                // Load wins when the decoder flags both classes.
                mem_read  = instr_is_load;
                mem_write = !instr_is_load;
                if (!waitrequest) begin
                    if (instr_is_load) begin
                        state_d = WB;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = pc_next_is_zero ? HALT : FETCH;
                    end
                end
            end
            WB: begin
                rf_write_enable = 1'b1;
                pc_write        = 1'b1;
                retire          = 1'b1;
                state_d         = pc_next_is_zero ? HALT : FETCH;
            end
            HALT: begin
                active = 1'b0;
            end
            default: begin
                // Unreachable encodings park the core safely.
                active  = 1'b0;
                state_d = HALT;
            end
        endcase

        // Reset dominates: no strobe may reach memory or the datapath.
        if (reset) begin
            active          = 1'b1;
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            ir_write        = 1'b0;
            pc_write        = 1'b0;
            rf_write_enable = 1'b0;
        end
    end

    assign state         = state_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
module tb_mips_cpu_control_fsm;

    localparam int CW = 4;
    localparam int S_FETCH = 0, S_EXEC = 1, S_MEM = 2, S_WB = 3, S_HALT = 4;
    localparam int NONE = 1 << 30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          waitrequest = 1'b0;
    logic          ld_i = 1'b0, st_i = 1'b0, wreg_i = 1'b0, pcz_i = 1'b0;
    logic          active, mem_read, mem_write, ir_write, pc_write, rf_write_enable;
    logic [2:0]    state;
    logic [CW-1:0] retired_count;

    mips_cpu_control_fsm #(.CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .waitrequest     (waitrequest),
        .instr_is_load   (ld_i),
        .instr_is_store  (st_i),
        .instr_writes_reg(wreg_i),
        .pc_next_is_zero (pcz_i),
        .active          (active),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .ir_write        (ir_write),
        .pc_write        (pc_write),
        .rf_write_enable (rf_write_enable),
        .state           (state),
        .retired_count   (retired_count)
    );

    always #5 clk = ~clk;

    // One record per clock: stimulus plus the outputs expected in that cycle.
    typedef struct {
        logic          rst, wr, ld, st, wreg, pcz;
        logic          act, mrd, mwr, irw, pcw, rfw;
        logic [2:0]    st_e;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t  tq[$];
    int    checks = 0;
    int    errors = 0;
    int    mcnt = 0;
    int    abort_cnt = NONE;
    bit    skip = 0;
    bit    halted = 0;
    string tag = "init";

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Instruction-level model: every retire commits the PC and vice versa,
    // so the count advances after each cycle whose expected pc_write is 1.
    task automatic push_rec(input logic rst, wr, ld, st, wreg, pcz, input int se,
                            input logic act, mrd, mwr, irw, pcw, rfw);
        vec_t v;
        v.rst = rst; v.wr = wr; v.ld = ld; v.st = st; v.wreg = wreg; v.pcz = pcz;
        v.act = act; v.mrd = mrd; v.mwr = mwr; v.irw = irw; v.pcw = pcw; v.rfw = rfw;
        v.st_e = 3'(se);
        v.cnt  = CW'(mcnt);
        tq.push_back(v);
        if (rst) mcnt = 0;
        else if (pcw) mcnt = (mcnt + 1) % (1 << CW);
    endtask

    // Normal cycle, unless the planned abort point is reached: then the cycle
    // becomes a reset (strobes low, active high) and the instruction is dropped.
    task automatic add(input logic wr, ld, st, wreg, pcz, input int se,
                       input logic act, mrd, mwr, irw, pcw, rfw);
        if (skip) return;
        if (abort_cnt == 0) begin
            push_rec(1, 1, rb(), rb(), rb(), rb(), se, 1, 0, 0, 0, 0, 0);
            skip = 1;
            return;
        end
        abort_cnt--;
        push_rec(0, wr, ld, st, wreg, pcz, se, act, mrd, mwr, irw, pcw, rfw);
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 load+store flagged together.
    // fw/mw: waitrequest cycles in fetch/mem. abort_at: cycle index for reset.
    task automatic gen_instr(input int kind, fw, mw, input logic wreg, pcz,
                             input int abort_at);
        logic ld, st;
        skip = 0;
        abort_cnt = abort_at;
        ld = logic'(kind == 1 || kind == 3);
        st = logic'(kind == 2 || kind == 3);
        repeat (fw) add(1, rb(), rb(), rb(), rb(), S_FETCH, 1, 1, 0, 0, 0, 0);
        add(0, rb(), rb(), rb(), rb(), S_FETCH, 1, 1, 0, 1, 0, 0);
        if (kind == 0) begin
            add(rb(), 0, 0, wreg, pcz, S_EXEC, 1, 0, 0, 0, 1, wreg);
        end else begin
            add(rb(), ld, st, rb(), rb(), S_EXEC, 1, 0, 0, 0, 0, 0);
            repeat (mw) add(1, ld, st, rb(), rb(), S_MEM, 1, ld, !ld, 0, 0, 0);
            if (ld) begin
                add(0, ld, st, rb(), rb(), S_MEM, 1, 1, 0, 0, 0, 0);
                add(rb(), ld, st, rb(), pcz, S_WB, 1, 0, 0, 0, 1, 1);
            end else begin
                add(0, ld, st, rb(), pcz, S_MEM, 1, 0, 1, 0, 1, 0);
            end
        end
        halted = pcz && !skip;
        abort_cnt = NONE;
        skip = 0;
    endtask

    task automatic halt_then_reset(input int n);
        repeat (n) add(rb(), rb(), rb(), rb(), rb(), S_HALT, 0, 0, 0, 0, 0, 0);
        push_rec(1, rb(), rb(), rb(), rb(), rb(), S_HALT, 1, 0, 0, 0, 0, 0);
        halted = 0;
    endtask

    task automatic run_trace();
        vec_t v;
        logic [12:0] got, exp;
        int idx;
        idx = 0;
        while (tq.size() > 0) begin
            v = tq.pop_front();
            @(negedge clk);
            reset = v.rst; waitrequest = v.wr; ld_i = v.ld; st_i = v.st;
            wreg_i = v.wreg; pcz_i = v.pcz;
            #1;
            got = {active, mem_read, mem_write, ir_write, pc_write, rf_write_enable,
                   state, retired_count};
            exp = {v.act, v.mrd, v.mwr, v.irw, v.pcw, v.rfw, v.st_e, v.cnt};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cyc%0d act/rd/wr/ir/pc/rf got=%b state=%0d cnt=%0d expected %b state=%0d cnt=%0d",
                         tag, idx, got[12:7], got[6:4], got[3:0], exp[12:7], exp[6:4], exp[3:0]);
            end
            idx++;
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Blind reset edge: state is unknown before it.
        reset = 1'b1;
        @(posedge clk);

        tag = "alu";
        push_rec(1, 0, 0, 0, 0, 0, S_FETCH, 1, 0, 0, 0, 0, 0);
        gen_instr(0, 0, 0, 1, 0, NONE);
        run_trace();
        @(negedge clk); reset = 0; waitrequest = 1; #1;
        check_val("alu_retired", int'(retired_count), 1);

        tag = "load_wait3";
        push_rec(1, 0, 0, 0, 0, 0, S_FETCH, 1, 0, 0, 0, 0, 0);
        gen_instr(1, 0, 3, 0, 0, NONE);
        run_trace();
        @(negedge clk); reset = 0; waitrequest = 1; #1;
        check_val("load_retired", int'(retired_count), 1);

        tag = "store_halt";
        gen_instr(2, 0, 0, 0, 1, NONE);
        halt_then_reset(10);
        run_trace();

        tag = "load_and_store";
        gen_instr(3, 1, 1, 0, 0, NONE);
        run_trace();

        tag = "reset_in_mem";
        gen_instr(1, 0, 3, 1, 0, 3);
        run_trace();
        @(negedge clk); reset = 0; waitrequest = 1; #1;
        check_val("reset_state", int'(state), S_FETCH);
        check_val("reset_count", int'(retired_count), 0);

        tag = "wrap";
        push_rec(1, 0, 0, 0, 0, 0, S_FETCH, 1, 0, 0, 0, 0, 0);
        repeat (17) gen_instr(0, 0, 0, rb(), 0, NONE);
        run_trace();
        @(negedge clk); reset = 0; waitrequest = 1; #1;
        check_val("wrap_count", int'(retired_count), 1);

        tag = "random";
        for (int i = 0; i < 300; i++) begin
            gen_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      rb(), logic'($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : NONE);
            if (halted) halt_then_reset($urandom_range(1, 5));
            run_trace();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
